// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath constants and the decoded control bundle.
// Imported by every pipeline stage.
package riscv_pkg;

    localparam int XLEN          = 32;
    localparam int REG_ADDR_SIZE = 5;
    localparam int OPCODE_SIZE   = 7;

    typedef struct packed {
        logic [2:0] ALUOp;
        logic       JumpReg;
        logic       Jump;
        logic       Branch;
        logic       RegSrc1;
        logic       RegSrc2;
        logic       UpperImm;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemToReg;
        logic       RetAddr;
        logic       imm;
        logic       rvfi_i_bool;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
// Produces the bubble request and the upstream hold.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  ctrl_t      id_ctrl,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_flush,
    input  logic       ex_stall,
    output logic       load_use,
    output logic       id_stall
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_ctrl.RegSrc1 & (id_rs1 == ex_rd);
    // Stores read rs2 as the store data even without RegSrc2.
    assign rs2_hit = (id_ctrl.RegSrc2 | id_ctrl.MemWrite)
                   & (id_rs2 == ex_rd);

    assign load_use = ex_valid & ex_mem_to_reg & (ex_rd != 5'd0)
                    & (rs1_hit | rs2_hit) & id_valid;

    assign id_stall = ~ex_flush & (ex_stall | load_use);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, stall, load-use bubble and
// same-cycle writeback bypass into the captured operands.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  ctrl_t           id_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    input  logic            ex_stall,
    output logic            ex_valid,
    output ctrl_t           ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            id_stall,
    output logic [15:0]     lu_count
);

    logic            load_use;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    load_use_detect u_lud (
        .ex_valid      (ex_valid),
        .ex_mem_to_reg (ex_ctrl.MemToReg),
        .ex_rd         (ex_rd),
        .id_valid      (id_valid),
        .id_ctrl       (id_ctrl),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_flush      (ex_flush),
        .ex_stall      (ex_stall),
        .load_use      (load_use),
        .id_stall      (id_stall)
    );

    // Register file is read before the WB write lands; forward it here.
    assign byp1    = wb_we & (wb_rd != 5'd0) & (wb_rd == id_rs1);
    assign byp2    = wb_we & (wb_rd != 5'd0) & (wb_rd == id_rs2);
    assign rs1_fwd = byp1 ? wb_data : id_rs1_data;
    assign rs2_fwd = byp2 ? wb_data : id_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            lu_count    <= '0;
        end else if (ex_flush || (!ex_stall && load_use)) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            if (!ex_flush && lu_count != 16'hFFFF)
                lu_count <= lu_count + 16'd1;
        end else if (!ex_stall) begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
            ex_pc       <= id_pc;
            ex_rs1_data <= rs1_fwd;
            ex_rs2_data <= rs2_fwd;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents queued at drive
// time and compared one cycle later.
module tb_id_ex_stage;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [14:0] ctrl;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    ctrl_t       id_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush, ex_stall;
    logic        ex_valid;
    ctrl_t       ex_ctrl;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        id_stall;
    logic [15:0] lu_count;

    int   checks = 0;
    int   passes = 0;
    exp_t q[$];

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .id_stall(id_stall),
        .lu_count(lu_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ctrl_t mk_ctrl(input logic mtr, input logic s1,
                                      input logic s2, input logic mw,
                                      input logic rw, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        c.MemToReg = mtr;
        c.RegSrc1  = s1;
        c.RegSrc2  = s2;
        c.MemWrite = mw;
        c.RegWrite = rw;
        c.ALUOp    = op;
        return c;
    endfunction

    task automatic drive(input logic v, input ctrl_t c, input logic [31:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] im,
                         input logic [2:0] f3, input logic f7);
        id_valid = v; id_ctrl = c; id_pc = pc;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = im;
        id_funct3 = f3; id_funct7b5 = f7;
    endtask

    function automatic exp_t mk(input logic v, input ctrl_t c,
                                input logic [31:0] pc, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] im, input logic [2:0] f3,
                                input logic f7);
        exp_t e;
        e = {v, c, pc, d1, d2, im, r1, r2, rd, f3, f7};
        return e;
    endfunction

    task automatic cyc(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            $error("FAIL %s_queue: observed empty expected entry", tag);
            return;
        end
        passes++;
        e = q.pop_front();
        chk({tag, "_valid"}, 160'(ex_valid), 160'(e.valid));
        chk({tag, "_ctrl"}, 160'(ex_ctrl), 160'(e.ctrl));
        chk({tag, "_data"},
            160'({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
                  ex_rs2, ex_rd, ex_funct3, ex_funct7b5}),
            160'({e.pc, e.rs1d, e.rs2d, e.imm, e.rs1, e.rs2, e.rd,
                  e.f3, e.f7}));
    endtask

    ctrl_t alu_c, lw_c, add_c, sw_c;
    exp_t  held;

    initial begin
        alu_c = mk_ctrl(0, 1, 0, 0, 1, 3'd0);
        lw_c  = mk_ctrl(1, 1, 0, 0, 1, 3'd0);
        add_c = mk_ctrl(0, 1, 1, 0, 1, 3'd0);
        sw_c  = mk_ctrl(0, 1, 0, 1, 0, 3'd0);
        rst_n = 1'b0;
        ex_flush = 0; ex_stall = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        drive(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_valid", 160'(ex_valid), 160'(0));
        chk("rst_pc", 160'(ex_pc), 160'(0));
        chk("rst_lu", 160'(lu_count), 160'(0));
        chk("rst_stall", 160'(id_stall), 160'(0));

        // ALU capture on first edge after reset release
        rst_n = 1'b1;
        drive(1, alu_c, 32'h100, 1, 2, 5, 32'h10, 32'h20, 32'h4, 3'd0, 0);
        q.push_back(mk(1, alu_c, 32'h100, 1, 2, 5, 32'h10, 32'h20, 32'h4,
                       3'd0, 0));
        cyc("alu");

        // Load-use: lw x7 then add using x7
        drive(1, lw_c, 32'h104, 2, 0, 7, 32'h80, 0, 32'h8, 3'd2, 0);
        q.push_back(mk(1, lw_c, 32'h104, 2, 0, 7, 32'h80, 0, 32'h8,
                       3'd2, 0));
        cyc("lw7");
        drive(1, add_c, 32'h108, 7, 1, 8, 32'h77, 32'h11, 0, 3'd0, 1);
        #1;
        chk("lu_stall", 160'(id_stall), 160'(1));
        q.push_back('0);
        cyc("bubble");
        chk("lu_cnt1", 160'(lu_count), 160'(1));
        chk("bubble_nostall", 160'(id_stall), 160'(0));
        q.push_back(mk(1, add_c, 32'h108, 7, 1, 8, 32'h77, 32'h11, 0,
                       3'd0, 1));
        cyc("add_after");

        // x0 destination never creates a hazard
        drive(1, lw_c, 32'h10c, 2, 0, 0, 32'h5, 0, 0, 3'd2, 0);
        q.push_back(mk(1, lw_c, 32'h10c, 2, 0, 0, 32'h5, 0, 0, 3'd2, 0));
        cyc("lwx0");
        drive(1, add_c, 32'h110, 0, 0, 9, 0, 0, 0, 3'd0, 0);
        #1;
        chk("x0_stall", 160'(id_stall), 160'(0));
        q.push_back(mk(1, add_c, 32'h110, 0, 0, 9, 0, 0, 0, 3'd0, 0));
        cyc("x0_cap");
        chk("x0_lu", 160'(lu_count), 160'(1));

        // Store data hazard through MemWrite on rs2
        drive(1, lw_c, 32'h114, 2, 0, 7, 32'h1, 0, 0, 3'd2, 0);
        q.push_back(mk(1, lw_c, 32'h114, 2, 0, 7, 32'h1, 0, 0, 3'd2, 0));
        cyc("lw7b");
        drive(1, sw_c, 32'h118, 3, 7, 0, 32'h2, 32'h3, 0, 3'd2, 0);
        #1;
        chk("sw_stall", 160'(id_stall), 160'(1));

        // Flush beats stall and load-use; no bubble counted
        ex_flush = 1; ex_stall = 1;
        #1;
        chk("flush_stall", 160'(id_stall), 160'(0));
        q.push_back('0);
        cyc("flush");
        chk("flush_lu", 160'(lu_count), 160'(1));
        ex_flush = 0; ex_stall = 0;

        // Writeback bypass: rs2 only, both, x0 exempt
        wb_we = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        drive(1, add_c, 32'h11c, 4, 3, 10, 32'h44, 0, 0, 3'd0, 0);
        q.push_back(mk(1, add_c, 32'h11c, 4, 3, 10, 32'h44, 32'hDEADBEEF,
                       0, 3'd0, 0));
        cyc("byp_rs2");
        drive(1, add_c, 32'h120, 3, 3, 10, 32'h1, 32'h2, 0, 3'd0, 0);
        q.push_back(mk(1, add_c, 32'h120, 3, 3, 10, 32'hDEADBEEF,
                       32'hDEADBEEF, 0, 3'd0, 0));
        cyc("byp_both");
        wb_rd = 0;
        drive(1, add_c, 32'h124, 4, 0, 10, 32'h44, 0, 0, 3'd0, 0);
        q.push_back(mk(1, add_c, 32'h124, 4, 0, 10, 32'h44, 0, 0,
                       3'd0, 0));
        cyc("byp_x0");
        wb_we = 0;

        // Invalid ID slot: ctrl zeroed, other fields still captured
        drive(0, add_c, 32'h128, 1, 2, 3, 32'h9, 32'h8, 32'h7, 3'd5, 1);
        q.push_back(mk(0, '0, 32'h128, 1, 2, 3, 32'h9, 32'h8, 32'h7,
                       3'd5, 1));
        cyc("invalid");

        // Stall hold with hazard and bypass pending, then async reset
        drive(1, lw_c, 32'h12c, 2, 0, 7, 32'h6, 0, 32'hC, 3'd2, 0);
        held = mk(1, lw_c, 32'h12c, 2, 0, 7, 32'h6, 0, 32'hC, 3'd2, 0);
        q.push_back(held);
        cyc("lw_hold");
        drive(1, add_c, 32'h130, 7, 7, 8, 32'h1, 32'h2, 0, 3'd0, 0);
        wb_we = 1; wb_rd = 7; wb_data = 32'hCAFE0000;
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            q.push_back(held);
            cyc("hold");
        end
        chk("hold_stall", 160'(id_stall), 160'(1));
        chk("hold_lu", 160'(lu_count), 160'(1));
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 160'(ex_valid), 160'(0));
        chk("arst_lu", 160'(lu_count), 160'(0));
        chk("arst_rd", 160'(ex_rd), 160'(0));
        ex_stall = 0;
        #1;
        chk("arst_nostall", 160'(id_stall), 160'(0));
        @(posedge clk);
        #1;
        wb_we = 0;
        rst_n = 1;
        drive(1, alu_c, 32'h200, 1, 2, 5, 32'h10, 32'h20, 0, 3'd0, 0);
        q.push_back(mk(1, alu_c, 32'h200, 1, 2, 5, 32'h10, 32'h20, 0,
                       3'd0, 0));
        cyc("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
